fsm_array_ctrl: RTL and testbench
=================================

FSM_ARRAY_CTRL -- requirements
Module: fsm_array_ctrl

Interface
REQ-001 SHALL have parameter P_NUM_CH, default 8: number of independent channel FSMs, legal range 1..64.
REQ-002 SHALL have parameter P_CNT_W, default 8: width of each per-channel dwell counter.
REQ-003 SHALL have parameter P_TIMEOUT, default 16: dwell timeout in enabled cycles; 0 disables timeout; legal range 0..2^P_CNT_W-1.
REQ-004 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_en  input  P_NUM_CH  per-channel enable; 0 freezes that channel's state and dwell counter.
REQ-007 SHALL have port i_adv  input  P_NUM_CH  per-channel advance strobe; a transition is taken only when it is 1.
REQ-008 SHALL have port i_cond  input  P_NUM_CH  per-channel transition condition, sampled with i_adv.
REQ-009 SHALL have port i_clr  input  P_NUM_CH  per-channel synchronous clear.
REQ-010 SHALL have port o_state  output  2*P_NUM_CH  registered state, channel n in bits [2n+1:2n].
REQ-011 SHALL have port o_timeout  output  P_NUM_CH  registered one-cycle timeout pulse per channel.
REQ-012 SHALL have port o_any_timeout  output  1  OR-reduction of o_timeout.
REQ-013 SHALL have port o_tr_cnt  output  8*P_NUM_CH  per-channel transition count, channel n in bits [8n+7:8n].

Function
REQ-014 Each channel SHALL be a 4-state FSM, encoding A=2'd0, B=2'd1, C=2'd2, D=2'd3; channels fully independent.
REQ-015 Advance table, applied when i_en=1, i_adv=1, and no higher-priority event: A: cond->B else C; B: cond->D else C; C: cond->A else D; D: cond->B else C.
REQ-016 Per-channel priority, highest first: i_clr (->A, dwell 0), i_en=0 (hold all), timeout (->A), i_adv (table), else hold.
REQ-017 Dwell counter SHALL load 0 on every state change and on i_clr; otherwise increment on each enabled edge, saturating at 2^P_CNT_W-1.
REQ-018 Timeout SHALL fire at an edge where P_TIMEOUT!=0, i_en=1, i_clr=0, state!=A, dwell==P_TIMEOUT-1; next state A regardless of i_adv.
REQ-019 Hence a non-A state held with i_en=1, i_adv=0 SHALL be visible on o_state for exactly P_TIMEOUT cycles before A.
REQ-020 o_timeout[n] SHALL be 1 for exactly the one cycle in which o_state first shows A due to timeout; 0 otherwise.
REQ-021 State A SHALL never time out; P_TIMEOUT=1 SHALL return any non-A state to A on the first enabled edge after entry.
REQ-022 Latency: inputs sampled at edge k SHALL be reflected on o_state/o_timeout after edge k; o_any_timeout combinational from o_timeout.

Reset
REQ-023 rstn low SHALL asynchronously force every channel to A, dwell 0, o_timeout 0, o_tr_cnt 0; o_any_timeout thus 0.
REQ-024 Reset assertion mid-dwell or mid-timeout SHALL discard the pending timeout; first evaluation after deassertion uses dwell 0.

Configuration
REQ-025 With macro FSM_ARRAY_TRCNT_EN defined, o_tr_cnt[n] SHALL count table transitions (REQ-015 only, not timeout/clr), saturate at 255, and clear to 0 on i_clr[n].
REQ-026 Without FSM_ARRAY_TRCNT_EN, o_tr_cnt SHALL be constant 0 and no counter logic SHALL be instantiated; all other behaviour identical.

Verification
REQ-027 Reset, ch0 i_en=1,i_adv=1, i_cond sequence 1,1,0,1 -> o_state[1:0] A,B,D,C,A.
REQ-028 P_TIMEOUT=4, ch2 enter B then i_adv=0,i_en=1 -> B for 4 cycles, then A with o_timeout[2]=1 and o_any_timeout=1 for 1 cycle.
REQ-029 ch1 in C, i_en=0 for 10 cycles mid-dwell then i_en=1 -> state held, timeout fires only after remaining enabled cycles.
REQ-030 Same edge i_clr=1,i_adv=1,i_en=0 on ch3 in D -> A next cycle, no o_timeout, o_tr_cnt[3] (TRCNT_EN) = 0.
REQ-031 TRCNT_EN, ch0 300 consecutive advances -> o_tr_cnt[7:0]=255; other channels' counts unaffected.
REQ-032 rstn pulsed low between clock edges during dwell==P_TIMEOUT-1 -> immediate A, no o_timeout pulse after release.

Source files
------------

// File: rtl/fsm_array_ctrl.sv
// fsm_array_ctrl: array of independent 4-state channel FSMs with dwell timeout.
// Define FSM_ARRAY_TRCNT_EN to build the per-channel saturating transition counters.
module fsm_array_ctrl #(
  parameter int P_NUM_CH  = 8,
  parameter int P_CNT_W   = 8,
  parameter int P_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [P_NUM_CH-1:0]   i_en,
  input  logic [P_NUM_CH-1:0]   i_adv,
  input  logic [P_NUM_CH-1:0]   i_cond,
  input  logic [P_NUM_CH-1:0]   i_clr,
  output logic [2*P_NUM_CH-1:0] o_state,
  output logic [P_NUM_CH-1:0]   o_timeout,
  output logic                  o_any_timeout,
  output logic [8*P_NUM_CH-1:0] o_tr_cnt
);
  typedef enum logic [1:0] {ST_A, ST_B, ST_C, ST_D} state_e;
  localparam bit                 TO_EN = P_TIMEOUT != 0;
  localparam logic [P_CNT_W-1:0] TO_M1 = P_CNT_W'(P_TIMEOUT == 0 ? 0 : P_TIMEOUT - 1);
  function automatic state_e adv_next(state_e s, logic c);
    return s == ST_A ? (c ? ST_B : ST_C) :
           s == ST_B ? (c ? ST_D : ST_C) :
           s == ST_C ? (c ? ST_A : ST_D) : (c ? ST_B : ST_C);
  endfunction
  for (genvar c = 0; c < P_NUM_CH; c++) begin : g_ch
    state_e             state_q;
    state_e             state_d;
    logic [P_CNT_W-1:0] dwell_q;
    logic               to_q;
    logic               fire;
    assign fire    = TO_EN && state_q != ST_A && dwell_q == TO_M1;
    assign state_d = adv_next(state_q, i_cond[c]);
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= ST_A;
        dwell_q <= '0;
        to_q    <= 1'b0;
      end else if (i_clr[c]) begin
        state_q <= ST_A;
        dwell_q <= '0;
        to_q    <= 1'b0;
      end else if (!i_en[c]) begin
        to_q    <= 1'b0;
      end else if (fire) begin
        state_q <= ST_A;
        dwell_q <= '0;
        to_q    <= 1'b1;
      end else if (i_adv[c]) begin
        state_q <= state_d;
        dwell_q <= '0;
        to_q    <= 1'b0;
      end else begin
        dwell_q <= dwell_q + P_CNT_W'(~&dwell_q);
        to_q    <= 1'b0;
      end
    end
    assign o_state[2*c+:2] = state_q;
    assign o_timeout[c]    = to_q;
`ifdef FSM_ARRAY_TRCNT_EN
    logic [7:0] tr_q;
    // only table transitions count; a timeout return to A does not
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) tr_q <= '0;
      else if (i_clr[c]) tr_q <= '0;
      else if (i_en[c] && !fire && i_adv[c] && tr_q != 8'hff) tr_q <= tr_q + 8'd1;
    end
    assign o_tr_cnt[8*c+:8] = tr_q;
`endif
  end
`ifndef FSM_ARRAY_TRCNT_EN
  assign o_tr_cnt = '0;
`endif
  assign o_any_timeout = |o_timeout;
endmodule

// File: tb/tb_fsm_array_ctrl.sv
// tb_fsm_array_ctrl: directed checks plus a per-cycle reference model of fsm_array_ctrl.
module tb_fsm_array_ctrl;
  localparam int NCH = 8;
  localparam int TO  = 4;
`ifdef FSM_ARRAY_TRCNT_EN
  localparam bit TRC = 1'b1;
`else
  localparam bit TRC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NCH-1:0] i_en = '0, i_adv = '0, i_cond = '0, i_clr = '0;
  logic [2*NCH-1:0] o_state;
  logic [NCH-1:0] o_timeout;
  logic o_any_timeout;
  logic [8*NCH-1:0] o_tr_cnt;
  int total = 0, bad = 0;
  int m_st [NCH] = '{default: 0};
  int m_dw [NCH] = '{default: 0};
  int m_to [NCH] = '{default: 0};
  int m_tr [NCH] = '{default: 0};
  int nxt [4][2] = '{'{2, 1}, '{2, 3}, '{3, 0}, '{2, 1}};

  fsm_array_ctrl #(.P_NUM_CH(NCH), .P_CNT_W(8), .P_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .i_en(i_en), .i_adv(i_adv), .i_cond(i_cond), .i_clr(i_clr),
    .o_state(o_state), .o_timeout(o_timeout), .o_any_timeout(o_any_timeout), .o_tr_cnt(o_tr_cnt));

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    for (int c = 0; c < NCH; c++) begin
      if (!rstn) begin
        m_st[c] <= 0; m_dw[c] <= 0; m_to[c] <= 0; m_tr[c] <= 0;
      end else if (i_clr[c]) begin
        m_st[c] <= 0; m_dw[c] <= 0; m_to[c] <= 0; m_tr[c] <= 0;
      end else if (!i_en[c]) begin
        m_to[c] <= 0;
      end else if (TO != 0 && m_st[c] != 0 && m_dw[c] == TO - 1) begin
        m_st[c] <= 0; m_dw[c] <= 0; m_to[c] <= 1;
      end else if (i_adv[c]) begin
        m_st[c] <= nxt[m_st[c]][int'(i_cond[c])];
        m_dw[c] <= 0; m_to[c] <= 0;
        m_tr[c] <= TRC ? (m_tr[c] < 255 ? m_tr[c] + 1 : 255) : 0;
      end else begin
        m_dw[c] <= m_dw[c] < 255 ? m_dw[c] + 1 : 255;
        m_to[c] <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [2*NCH-1:0] es;
    logic [NCH-1:0] et;
    logic [8*NCH-1:0] ec;
    for (int c = 0; c < NCH; c++) begin
      es[2*c+:2] = 2'(m_st[c]);
      et[c] = m_to[c] != 0;
      ec[8*c+:8] = 8'(m_tr[c]);
    end
    chk("model_state", 64'(o_state), 64'(es));
    chk("model_timeout", 64'(o_timeout), 64'(et));
    chk("model_any", 64'(o_any_timeout), 64'(|et));
    chk("model_trcnt", o_tr_cnt, ec);
  end

  task automatic set(input int c, input logic en, input logic adv, input logic cond, input logic clr);
    i_en[c] = en; i_adv[c] = adv; i_cond[c] = cond; i_clr[c] = clr;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    step(2);
    #2 rstn = 1'b1;
    step(1);
    chk("reset_state", 64'(o_state), 64'd0);
    chk("reset_timeout", 64'(o_timeout), 64'd0);
    chk("reset_trcnt", o_tr_cnt, 64'd0);
    // ch0 walk A->B->D->C->A
    set(0, 1, 1, 1, 0); step(1); chk("walk_b", 64'(o_state[1:0]), 64'd1);
    set(0, 1, 1, 1, 0); step(1); chk("walk_d", 64'(o_state[1:0]), 64'd3);
    set(0, 1, 1, 0, 0); step(1); chk("walk_c", 64'(o_state[1:0]), 64'd2);
    set(0, 1, 1, 1, 0); step(1); chk("walk_a", 64'(o_state[1:0]), 64'd0);
    chk("walk_trcnt", 64'(o_tr_cnt[7:0]), TRC ? 64'd4 : 64'd0);
    set(0, 0, 0, 0, 0);
    // ch2 dwell timeout
    set(2, 1, 1, 1, 0); step(1); chk("to_b0", 64'(o_state[5:4]), 64'd1);
    set(2, 1, 0, 0, 0);
    for (int i = 1; i < 4; i++) begin
      step(1); chk("to_bhold", 64'(o_state[5:4]), 64'd1);
      chk("to_nopulse", 64'(o_timeout[2]), 64'd0);
    end
    step(1); chk("to_a", 64'(o_state[5:4]), 64'd0);
    chk("to_pulse", 64'(o_timeout[2]), 64'd1);
    chk("to_any", 64'(o_any_timeout), 64'd1);
    step(1); chk("to_pulse_end", 64'(o_timeout[2]), 64'd0);
    set(2, 0, 0, 0, 0);
    // ch1 frozen mid-dwell
    set(1, 1, 1, 0, 0); step(1); chk("frz_c", 64'(o_state[3:2]), 64'd2);
    set(1, 1, 0, 0, 0); step(2);
    set(1, 0, 1, 1, 0); step(10); chk("frz_hold", 64'(o_state[3:2]), 64'd2);
    set(1, 1, 0, 0, 0); step(1); chk("frz_last", 64'(o_state[3:2]), 64'd2);
    step(1); chk("frz_a", 64'(o_state[3:2]), 64'd0);
    chk("frz_pulse", 64'(o_timeout[1]), 64'd1);
    set(1, 0, 0, 0, 0);
    // ch3 clear beats disable and advance
    set(3, 1, 1, 1, 0); step(2); chk("clr_d", 64'(o_state[7:6]), 64'd3);
    set(3, 0, 1, 1, 1); step(1); chk("clr_a", 64'(o_state[7:6]), 64'd0);
    chk("clr_noto", 64'(o_timeout[3]), 64'd0);
    chk("clr_trcnt", 64'(o_tr_cnt[31:24]), 64'd0);
    set(3, 0, 0, 0, 0);
    // reset pulse while ch2 sits at dwell == TO-1
    set(2, 1, 1, 1, 0); step(1);
    set(2, 1, 0, 0, 0); step(3);
    chk("rst_pre_b", 64'(o_state[5:4]), 64'd1);
    #2 rstn = 1'b0;
    #1 chk("rst_async", 64'(o_state), 64'd0);
    #1 rstn = 1'b1;
    step(1); chk("rst_a", 64'(o_state[5:4]), 64'd0);
    chk("rst_noto", 64'(o_timeout[2]), 64'd0);
    step(4); chk("rst_a_stays", 64'(o_state[5:4]), 64'd0);
    set(2, 0, 0, 0, 0);
    // counter saturation on ch0, ten advances on ch5
    for (int i = 0; i < 300; i++) begin
      set(0, 1, 1, 1'($urandom), 0);
      set(5, 1, i < 10, 1'($urandom), 0);
      step(1);
    end
    chk("sat_ch0", 64'(o_tr_cnt[7:0]), TRC ? 64'd255 : 64'd0);
    chk("sat_ch5", 64'(o_tr_cnt[47:40]), TRC ? 64'd10 : 64'd0);
    chk("sat_ch2", 64'(o_tr_cnt[23:16]), 64'd0);
    set(0, 1, 0, 0, 1); step(1);
    chk("sat_clr", 64'(o_tr_cnt[7:0]), 64'd0);
    // random traffic, model compared every cycle
    for (int i = 0; i < 400; i++) begin
      i_en = NCH'($urandom) | NCH'($urandom);
      i_adv = NCH'($urandom) & NCH'($urandom);
      i_cond = NCH'($urandom);
      i_clr = NCH'($urandom) & NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
      step(1);
    end
    i_en = '0; i_adv = '0; i_cond = '0; i_clr = '0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
